// File: rtl/up_second.sv
// ---------------------------------------------------------------------------
// up_second: BCD seconds up-counter (00..59) for the timer/stopwatch datapath.
//
// - Clocked by the divided tick clock clk_out; all state is registered.
// - Synchronous active-high reset (rst) clears the digits, the carry and the
//   run/stop FSM.
// - switch=1 loads the preset digits, clamped to the digit limits, and forces
//   the FSM to STOP. Holding switch high reloads on every edge.
// - In RUN, each edge with inc_in=1 advances the count. The wrap from
//   SEC1_LIMIT:SEC0_LIMIT to 00 raises carry_sec for exactly one cycle, so a
//   minutes stage can cascade from it.
// - Optional build macro UP_SECOND_SAT_EN: when defined, the count saturates
//   at SEC1_LIMIT:SEC0_LIMIT and no carry is produced. When undefined, the
//   count wraps to 00 with a carry pulse.
//
// Enable qualifier: inc_in is a level-sensitive count enable from the
// previous stage. It is sampled on every rising edge of clk_out and has no
// handshake back-pressure. One count is taken per edge where the registered
// state is RUN, switch=0 and inc_in=1.
//
// Debug visibility: the FSM state is exported directly on 'running'.
// ---------------------------------------------------------------------------
module up_second #(
    parameter logic [3:0] SEC1_LIMIT = 4'd5,
    parameter logic [3:0] SEC0_LIMIT = 4'd9
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic [1:0] alu,
    input  logic       switch,
    input  logic [3:0] in_sec1,
    input  logic [3:0] in_sec0,
    input  logic       inc_in,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       carry_sec,
    output logic       running
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sec1_q, sec1_d;
    logic [3:0] sec0_q, sec0_d;
    logic       carry_q, carry_d;

    logic [3:0] load_sec1;
    logic [3:0] load_sec0;
    logic       count_en;
    logic       sec0_at_limit;
    logic       sec1_at_limit;

    // Preset digits clamped to their limits so a load can never create an
    // illegal BCD value.
    always_comb begin
        load_sec1 = (in_sec1 > SEC1_LIMIT) ? SEC1_LIMIT : in_sec1;
        load_sec0 = (in_sec0 > SEC0_LIMIT) ? SEC0_LIMIT : in_sec0;
    end

    // Counting is qualified by the registered state, so a change on alu
    // takes effect one cycle later.
    always_comb begin
        count_en      = (state_q == ST_RUN) && !switch && inc_in;
        sec0_at_limit = (sec0_q >= SEC0_LIMIT);
        sec1_at_limit = (sec1_q >= SEC1_LIMIT);
    end

    // Run/stop FSM next state. A load forces STOP. After switch falls, the
    // FSM therefore spends one cycle in STOP before entering RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if ((alu != 2'b00) && !switch) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((alu == 2'b00) || switch) begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Digit and carry next state, in priority order: load, then count,
    // then hold. The carry defaults to 0, which makes it a single-cycle pulse.
    always_comb begin
        sec1_d  = sec1_q;
        sec0_d  = sec0_q;
        carry_d = 1'b0;
        if (switch) begin
            sec1_d = load_sec1;
            sec0_d = load_sec0;
        end else if (count_en) begin
            if (!sec0_at_limit) begin
                sec0_d = sec0_q + 4'd1;
            end else if (!sec1_at_limit) begin
                sec0_d = 4'd0;
                sec1_d = sec1_q + 4'd1;
            end else begin
`ifdef UP_SECOND_SAT_EN
                // Saturate at the top value: hold the digits, no carry.
                sec1_d = sec1_q;
                sec0_d = sec0_q;
`else
                // Wrap to 00 and tell the minutes stage to advance.
                sec1_d  = 4'd0;
                sec0_d  = 4'd0;
                carry_d = 1'b1;
`endif
            end
        end
    end

    // State register with synchronous reset that overrides every other input.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            state_q <= ST_STOP;
            sec1_q  <= 4'd0;
            sec0_q  <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sec1_q  <= sec1_d;
            sec0_q  <= sec0_d;
            carry_q <= carry_d;
        end
    end

    // Drive the outputs straight from the registers.
    always_comb begin
        sec1      = sec1_q;
        sec0      = sec0_q;
        carry_sec = carry_q;
        running   = (state_q == ST_RUN);
    end

endmodule
